// File: rtl/stall_pipe_chain.sv
// rtl/stall_pipe_chain.sv - parametrised valid/ready_go/allow_in pipeline chain with flush and commit port
// Stage k holds one DW-bit item; external combinational logic feeds stage_din and reads stage_dout.
module stall_pipe_chain #(
  parameter int              STAGES     = 3,
  parameter int              DW         = 64,
  parameter int              CW         = 64,
  parameter logic [CW-1:0]   COMMIT_RST = CW'(64'h80000000),
  parameter int              RGW        = 32,
  localparam int             OW         = $clog2(STAGES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validin,
  output logic                 in_ready,
  input  logic [STAGES*DW-1:0] stage_din,
  input  logic [STAGES-1:0]    ready_go,
  input  logic [STAGES-1:0]    flush,
  input  logic                 out_allow,
  output logic [STAGES*DW-1:0] stage_dout,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES-1:0]    stage_load,
  output logic                 validout,
  output logic [OW-1:0]        occupancy,
  output logic                 commit_valid,
  output logic [CW-1:0]        commit_data,
  output logic [RGW-1:0]       retire_count
);

  logic [STAGES-1:0] r_valid;
  logic [DW-1:0]     r_data [STAGES];
  logic              r_commit_valid;
  logic [CW-1:0]     r_commit_data;
  logic [RGW-1:0]    r_retire_count;

  logic [STAGES-1:0] w_allow;
  logic [STAGES-1:0] w_to_next;
  logic [STAGES-1:0] w_up_v;
  logic [STAGES-1:0] w_load;
  logic              w_down;
  logic              w_retire;
  logic [OW-1:0]     w_occ;

  assign w_to_next = r_valid & ready_go & ~flush;

  // allow_in ripples from the sink back to stage 0; w_down carries allow_in[k+1]
  always_comb begin
    w_allow = '0;
    w_down  = out_allow;
    for (int k = STAGES-1; k >= 0; k--) begin
      w_allow[k] = !flush[k] && (!r_valid[k] || (ready_go[k] && w_down));
      w_down     = w_allow[k];
    end
  end

  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = validin;
    for (int k = 1; k < STAGES; k++) begin
      w_up_v[k] = w_to_next[k-1];
    end
  end

  assign w_load   = w_up_v & w_allow;
  assign w_retire = w_to_next[STAGES-1] && out_allow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          r_valid[k] <= 1'b0;
        end else if (w_allow[k]) begin
          r_valid[k] <= w_up_v[k];
        end
        if (w_load[k]) begin
          r_data[k] <= stage_din[k*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_valid <= 1'b0;
      r_commit_data  <= COMMIT_RST;
      r_retire_count <= '0;
    end else begin
      r_commit_valid <= w_retire;
      if (w_retire) begin
        r_commit_data  <= r_data[STAGES-1][CW-1:0];
        r_retire_count <= r_retire_count + RGW'(1);
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + OW'(r_valid[k]);
    end
  end

  always_comb begin
    stage_dout = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_dout[k*DW +: DW] = r_data[k];
    end
  end

  assign in_ready     = w_allow[0];
  assign stage_valid  = r_valid;
  assign stage_load   = w_load;
  assign validout     = w_to_next[STAGES-1];
  assign occupancy    = w_occ;
  assign commit_valid = r_commit_valid;
  assign commit_data  = r_commit_data;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_stall_pipe_chain.sv
// tb/tb_stall_pipe_chain.sv - directed vector bench for stall_pipe_chain (3 stages, 8-bit data, 4-bit retire count)
module tb_stall_pipe_chain;

  localparam int S   = 3;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int RGW = 4;
  localparam logic [7:0] CRST = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          validin;
  logic          in_ready;
  logic [23:0]   stage_din;
  logic [2:0]    ready_go;
  logic [2:0]    flush;
  logic          out_allow;
  logic [23:0]   stage_dout;
  logic [2:0]    stage_valid;
  logic [2:0]    stage_load;
  logic          validout;
  logic [1:0]    occupancy;
  logic          commit_valid;
  logic [7:0]    commit_data;
  logic [3:0]    retire_count;
  logic [7:0]    din0;

  int checks = 0;
  int failures = 0;

  // stages 1..2 simply pass the previous stage's contents through
  assign stage_din = {stage_dout[15:0], din0};

  stall_pipe_chain #(
    .STAGES(S), .DW(DW), .CW(CW), .COMMIT_RST(CRST), .RGW(RGW)
  ) dut (
    .clk(clk), .rst(rst), .validin(validin), .in_ready(in_ready),
    .stage_din(stage_din), .ready_go(ready_go), .flush(flush),
    .out_allow(out_allow), .stage_dout(stage_dout), .stage_valid(stage_valid),
    .stage_load(stage_load), .validout(validout), .occupancy(occupancy),
    .commit_valid(commit_valid), .commit_data(commit_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] valid;
    logic       in_ready;
    logic [2:0] load;
    logic       validout;
    logic [1:0] occ;
    logic       cv;
    logic [7:0] cd;
    logic [3:0] rc;
  } exp_t;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic [2:0] rg;
    logic [2:0] fl;
    logic       oa;
    exp_t       e;
  } vec_t;

  vec_t vecs[20];
  int   nvec = 0;

  task automatic add(input logic vin, input logic [7:0] din, input logic oa,
                     input logic [2:0] v, input logic ir, input logic [2:0] ld,
                     input logic vo, input logic [1:0] occ, input logic cv,
                     input logic [7:0] cd, input logic [3:0] rc);
    vecs[nvec].vin = vin;
    vecs[nvec].din = din;
    vecs[nvec].rg  = 3'b111;
    vecs[nvec].fl  = 3'b000;
    vecs[nvec].oa  = oa;
    vecs[nvec].e   = '{v, ir, ld, vo, occ, cv, cd, rc};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vin, input logic [7:0] din, input logic [2:0] rg,
                       input logic [2:0] fl, input logic oa);
    validin   = vin;
    din0      = din;
    ready_go  = rg;
    flush     = fl;
    out_allow = oa;
  endtask

  exp_t act;
  int   ncommit;
  int   first_idx;
  int   max_occ;
  logic [7:0] cd_seen [2];

  initial begin
    // streaming three items through an unstalled pipe
    add(1, 8'h11, 1, 3'b000, 1, 3'b001, 0, 0, 0, CRST,  0);
    add(1, 8'h22, 1, 3'b001, 1, 3'b011, 0, 1, 0, CRST,  0);
    add(1, 8'h33, 1, 3'b011, 1, 3'b111, 0, 2, 0, CRST,  0);
    add(0, 8'h00, 1, 3'b111, 1, 3'b110, 1, 3, 0, CRST,  0);
    add(0, 8'h00, 1, 3'b110, 1, 3'b100, 1, 2, 1, 8'h11, 1);
    add(0, 8'h00, 1, 3'b100, 1, 3'b000, 1, 1, 1, 8'h22, 2);
    add(0, 8'h00, 1, 3'b000, 1, 3'b000, 0, 0, 1, 8'h33, 3);
    add(0, 8'h00, 1, 3'b000, 1, 3'b000, 0, 0, 0, 8'h33, 3);
    // sink back-pressure with a full pipe, then a single accept
    add(1, 8'h03, 0, 3'b000, 1, 3'b001, 0, 0, 0, 8'h33, 3);
    add(1, 8'h02, 0, 3'b001, 1, 3'b011, 0, 1, 0, 8'h33, 3);
    add(1, 8'h01, 0, 3'b011, 1, 3'b111, 0, 2, 0, 8'h33, 3);
    add(1, 8'h44, 0, 3'b111, 0, 3'b000, 1, 3, 0, 8'h33, 3);
    add(1, 8'h44, 0, 3'b111, 0, 3'b000, 1, 3, 0, 8'h33, 3);
    add(1, 8'h44, 1, 3'b111, 1, 3'b111, 1, 3, 0, 8'h33, 3);
    add(0, 8'h00, 0, 3'b111, 0, 3'b000, 1, 3, 1, 8'h03, 4);
    add(0, 8'h00, 1, 3'b111, 1, 3'b110, 1, 3, 0, 8'h03, 4);
    add(0, 8'h00, 1, 3'b110, 1, 3'b100, 1, 2, 1, 8'h02, 5);
    add(0, 8'h00, 1, 3'b100, 1, 3'b000, 1, 1, 1, 8'h01, 6);
    add(0, 8'h00, 1, 3'b000, 1, 3'b000, 0, 0, 1, 8'h44, 7);
    add(0, 8'h00, 1, 3'b000, 1, 3'b000, 0, 0, 0, 8'h44, 7);

    rst = 1'b1;
    drive(0, 8'h00, 3'b111, 3'b000, 1);
    @(negedge clk);
    #1;
    chk("reset_valid", 32'(stage_valid), 32'h0);
    chk("reset_commit", 32'({commit_valid, commit_data}), 32'({1'b0, CRST}));
    chk("reset_rc", 32'(retire_count), 32'h0);
    chk("reset_dout", 32'(stage_dout), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      drive(vecs[i].vin, vecs[i].din, vecs[i].rg, vecs[i].fl, vecs[i].oa);
      #1;
      act = '{stage_valid, in_ready, stage_load, validout, occupancy,
              commit_valid, commit_data, retire_count};
      chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].e));
    end

    // stage 1 stalled with A5 while stage 0 holds B6
    @(negedge clk); drive(1, 8'hA5, 3'b111, 3'b000, 1);
    @(negedge clk); drive(1, 8'hB6, 3'b101, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 8'hC7, 3'b101, 3'b000, 1);
      #1;
      chk($sformatf("stall%0d_state", i),
          32'({in_ready, stage_valid, stage_load, occupancy}),
          32'({1'b0, 3'b011, 3'b000, 2'd2}));
      chk($sformatf("stall%0d_data", i), 32'(stage_dout[15:0]), 32'h0000A5B6);
    end
    ncommit = 0; first_idx = -1; max_occ = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 8'h00, 3'b111, 3'b000, 1);
      #1;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (commit_valid) begin
        if (ncommit == 0) first_idx = i;
        if (ncommit < 2) cd_seen[ncommit] = commit_data;
        ncommit++;
      end
    end
    chk("stall_ncommit", 32'(ncommit), 32'd2);
    chk("stall_order", 32'({cd_seen[0], cd_seen[1]}), 32'h0000A5B6);
    chk("stall_back_to_back", 32'(first_idx), 32'd2);
    chk("stall_max_occ", 32'(max_occ), 32'd2);
    chk("stall_rc", 32'(retire_count), 32'd9);

    // flush stages 0 and 1 of a full pipe while stage 2 retires
    @(negedge clk); drive(1, 8'hD3, 3'b111, 3'b000, 0);
    @(negedge clk); drive(1, 8'hD2, 3'b111, 3'b000, 0);
    @(negedge clk); drive(1, 8'hD1, 3'b111, 3'b000, 0);
    @(negedge clk); drive(1, 8'hEE, 3'b111, 3'b011, 1);
    #1;
    chk("flush_pre", 32'({stage_valid, stage_load, in_ready, validout}),
        32'({3'b111, 3'b000, 1'b0, 1'b1}));
    @(negedge clk); drive(0, 8'h00, 3'b111, 3'b000, 0);
    #1;
    chk("flush_post", 32'({stage_valid, commit_valid, commit_data, retire_count}),
        32'({3'b000, 1'b1, 8'hD3, 4'd10}));
    @(negedge clk);
    #1;
    chk("flush_rc_hold", 32'({commit_valid, retire_count}), 32'({1'b0, 4'd10}));

    // asynchronous reset with two items in flight
    @(negedge clk); drive(1, 8'h61, 3'b111, 3'b000, 1);
    @(negedge clk); drive(1, 8'h62, 3'b111, 3'b000, 1);
    @(negedge clk); drive(0, 8'h00, 3'b111, 3'b000, 1);
    #1;
    chk("areset_inflight", 32'(stage_valid), 32'b011);
    #1;
    rst = 1'b1;
    #1;
    chk("areset_state", 32'({stage_valid, commit_valid, commit_data, retire_count}),
        32'({3'b000, 1'b0, CRST, 4'd0}));
    chk("areset_dout", 32'(stage_dout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 17 retires wrap the 4-bit retire counter to 1
    ncommit = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i < 17) drive(1, 8'(i + 1), 3'b111, 3'b000, 1);
      else        drive(0, 8'h00, 3'b111, 3'b000, 1);
      #1;
      if (commit_valid) ncommit++;
    end
    chk("wrap_ncommit", 32'(ncommit), 32'd17);
    chk("wrap_rc", 32'(retire_count), 32'd1);
    chk("wrap_last_data", 32'(commit_data), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
